// File: rtl/puf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : puf_pkg
// Description : Shared definitions for the bistable ring PUF controller.
//               Holds the controller state encoding, the challenge LFSR
//               polynomial and the LFSR step/seed helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package puf_pkg;

  // Ring stage count; the LFSR and challenge bus are this wide.
  localparam int CHAL_W_DEF = 32;

  // Galois feedback mask, applied when the bit shifted out is 1.
  localparam logic [CHAL_W_DEF-1:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_SHIFT  = 3'd4,
    ST_OUTPUT = 3'd5
  } state_e;

  // One right-shift Galois step; the LSB is the feedback bit.
  function automatic logic [CHAL_W_DEF-1:0] lfsr_step(input logic [CHAL_W_DEF-1:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction

  // The all-zero state is a lock-up state, so a zero seed becomes 1.
  function automatic logic [CHAL_W_DEF-1:0] lfsr_seed_fix(input logic [CHAL_W_DEF-1:0] s);
    lfsr_seed_fix = (s == '0) ? {{(CHAL_W_DEF-1){1'b0}}, 1'b1} : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : puf_lfsr
// Description : Challenge generator. 32-bit Galois LFSR, shift right.
//               load    - capture seed (zero seed substituted by 1)
//               advance - step once (ignored when load is high)
//               state   - current LFSR value
// Revision    : 1.0 - initial release
// ============================================================================
module puf_lfsr
  import puf_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [CHAL_W_DEF-1:0] seed,
  input  logic                  advance,
  output logic [CHAL_W_DEF-1:0] state
);

  logic [CHAL_W_DEF-1:0] state_q;
  logic [CHAL_W_DEF-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = lfsr_seed_fix(seed);
    end else if (advance) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule
`default_nettype wire

// File: rtl/bistable_ring_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bistable_ring_ctrl
// Description : Challenge driver / evaluator for a bistable ring PUF.
//               Applies LFSR challenges, runs the ring reset/release cycle,
//               majority-votes VOTES synchronized samples into one bit and
//               packs OUT_W bits (first bit in MSB) into words.
//   Ports: start/seed/n_words/abort - run control; busy/done - run status;
//          ring_challenge/ring_reset/ring_response - ring interface;
//          word_data/word_valid/word_ready - output word handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bistable_ring_ctrl
  import puf_pkg::*;
#(
  parameter int CHAL_W     = CHAL_W_DEF,
  parameter int OUT_W      = 32,
  parameter int RST_CYC    = 8,
  parameter int SETTLE_CYC = 64,
  parameter int VOTES      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [CHAL_W-1:0] seed,
  input  logic [7:0]        n_words,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [CHAL_W-1:0] ring_challenge,
  output logic              ring_reset,
  input  logic              ring_response,
  output logic [OUT_W-1:0]  word_data,
  output logic              word_valid,
  input  logic              word_ready
);

  localparam int CYC_MAX = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam int VOTE_W  = $clog2(VOTES + 1);
  localparam int BIT_W   = $clog2(OUT_W + 1);

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [VOTE_W-1:0]   vote_cnt_q, vote_cnt_d;
  logic [VOTE_W-1:0]   ones_cnt_q, ones_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]          words_left_q, words_left_d;
  // Holds the first OUT_W-1 bits of a word; the last bit is taken straight
  // from the vote when the word is completed.
  logic [OUT_W-2:0]    word_shift_q, word_shift_d;
  logic [OUT_W-1:0]    word_data_q, word_data_d;
  logic                word_valid_q, word_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ring_reset_q, ring_reset_d;
  logic [CHAL_W-1:0]   ring_challenge_q, ring_challenge_d;
  logic                sync1_q, sync2_q;

  logic                lfsr_load;
  logic                lfsr_adv;
  logic [CHAL_W-1:0]   lfsr_state;
  logic                vote_bit;

  puf_lfsr u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .seed    (seed),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  assign vote_bit = (ones_cnt_q > VOTE_W'(VOTES / 2));

  always_comb begin
    state_d          = state_q;
    cyc_cnt_d        = cyc_cnt_q;
    vote_cnt_d       = vote_cnt_q;
    ones_cnt_d       = ones_cnt_q;
    bit_cnt_d        = bit_cnt_q;
    words_left_d     = words_left_q;
    word_shift_d     = word_shift_q;
    word_data_d      = word_data_q;
    word_valid_d     = word_valid_q;
    busy_d           = busy_q;
    done_d           = 1'b0;
    ring_challenge_d = ring_challenge_q;
    lfsr_load        = 1'b0;
    lfsr_adv         = 1'b0;

    // The challenge register is only ever updated on entry to LOAD, so it
    // changes exclusively while the ring is held in reset.
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          lfsr_load    = 1'b1;
          words_left_d = n_words;
          cyc_cnt_d    = '0;
          vote_cnt_d   = '0;
          ones_cnt_d   = '0;
          bit_cnt_d    = '0;
          word_shift_d = '0;
          if (n_words == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d          = ST_LOAD;
            busy_d           = 1'b1;
            ring_challenge_d = lfsr_seed_fix(seed);
          end
        end
      end

      ST_LOAD: begin
        if (cyc_cnt_q == CYC_W'(RST_CYC - 1)) begin
          cyc_cnt_d = '0;
          state_d   = ST_SETTLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      ST_SETTLE: begin
        if (cyc_cnt_q == CYC_W'(SETTLE_CYC - 1)) begin
          cyc_cnt_d = '0;
          state_d   = ST_SAMPLE;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end

      ST_SAMPLE: begin
        ones_cnt_d = ones_cnt_q + VOTE_W'(sync2_q);
        vote_cnt_d = vote_cnt_q + 1'b1;
        if (vote_cnt_d < VOTE_W'(VOTES)) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        lfsr_adv   = 1'b1;
        ones_cnt_d = '0;
        vote_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q + 1'b1;
        if (bit_cnt_d == BIT_W'(OUT_W)) begin
          bit_cnt_d    = '0;
          word_data_d  = {word_shift_q, vote_bit};
          word_shift_d = '0;
          word_valid_d = 1'b1;
          state_d      = ST_OUTPUT;
        end else begin
          word_shift_d     = {word_shift_q[OUT_W-3:0], vote_bit};
          state_d          = ST_LOAD;
          // The LFSR steps this cycle; present its next value directly.
          ring_challenge_d = lfsr_step(lfsr_state);
        end
      end

      ST_OUTPUT: begin
        if (word_ready) begin
          word_valid_d = 1'b0;
          words_left_d = words_left_q - 1'b1;
          if (words_left_q == 8'd1) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d          = ST_LOAD;
            ring_challenge_d = lfsr_state;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides everything, including a same-cycle handshake.
    if (abort && (state_q != ST_IDLE)) begin
      state_d          = ST_IDLE;
      busy_d           = 1'b0;
      done_d           = 1'b0;
      word_valid_d     = 1'b0;
      words_left_d     = words_left_q;
      cyc_cnt_d        = '0;
      vote_cnt_d       = '0;
      ones_cnt_d       = '0;
      bit_cnt_d        = '0;
      word_shift_d     = '0;
      ring_challenge_d = ring_challenge_q;
      lfsr_adv         = 1'b0;
    end

    ring_reset_d = !((state_d == ST_SETTLE) || (state_d == ST_SAMPLE));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      cyc_cnt_q        <= '0;
      vote_cnt_q       <= '0;
      ones_cnt_q       <= '0;
      bit_cnt_q        <= '0;
      words_left_q     <= '0;
      word_shift_q     <= '0;
      word_data_q      <= '0;
      word_valid_q     <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      ring_reset_q     <= 1'b1;
      ring_challenge_q <= '0;
      sync1_q          <= 1'b0;
      sync2_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      cyc_cnt_q        <= cyc_cnt_d;
      vote_cnt_q       <= vote_cnt_d;
      ones_cnt_q       <= ones_cnt_d;
      bit_cnt_q        <= bit_cnt_d;
      words_left_q     <= words_left_d;
      word_shift_q     <= word_shift_d;
      word_data_q      <= word_data_d;
      word_valid_q     <= word_valid_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      ring_reset_q     <= ring_reset_d;
      ring_challenge_q <= ring_challenge_d;
      sync1_q          <= ring_response;
      sync2_q          <= sync1_q;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign ring_challenge = ring_challenge_q;
  assign ring_reset     = ring_reset_q;
  assign word_data      = word_data_q;
  assign word_valid     = word_valid_q;

endmodule
`default_nettype wire

// File: doc/bistable_ring_ctrl.md
Name: bistable_ring_ctrl

Overview:
Challenge-side driver and evaluator for the 32-stage bistable ring PUF.
- Generates challenges from a seeded LFSR and applies each to the ring.
- Runs the ring reset/release sequence, samples the asynchronous response through a synchronizer, and majority-votes repeated evaluations into one bit per challenge.
- Packs bits into words delivered over a valid/ready handshake to the readout logic.

Parameters:
- CHAL_W, 32, challenge width; must match the ring stage count.
- OUT_W, 32, response bits per output word.
- RST_CYC, 8, cycles ring_reset is held high per evaluation (≥1).
- SETTLE_CYC, 64, cycles after release before sampling (≥3, so the synchronizer is covered).
- VOTES, 5, evaluations per challenge; odd, ≥1.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run; ignored while busy.
- seed  input  CHAL_W  LFSR seed, captured on start.
- n_words  input  8  words to produce, captured on start.
- abort  input  1  synchronous; terminates the run.
- busy  output  1  high from the cycle after start until the run ends.
- done  output  1  one-cycle pulse at normal completion.
- ring_challenge  output  CHAL_W  registered challenge to the ring.
- ring_reset  output  1  registered, active-high ring reset.
- ring_response  input  1  asynchronous ring output.
- word_data  output  OUT_W  packed response word.
- word_valid  output  1  word_data is valid.
- word_ready  input  1  consumer accepts the word.

Behaviour:
- Reset values: ring_challenge=0, ring_reset=1, busy=0, done=0, word_valid=0, word_data=0. All internal counters, the LFSR and the synchronizer clear.
- ring_reset is 1 in every state except SETTLE and SAMPLE. ring_challenge changes only in a cycle where ring_reset is 1.
- ring_response passes through a 2-flop synchronizer. Only the synchronized value is used.
- LFSR: 32-bit Galois, mask 0x80200003, shift right; feedback is the LSB.
  - seed==0 loads 0x00000001.
  - The LFSR advances once per completed bit, after voting.
  - The first challenge applied is the loaded seed.
- FSM states: IDLE, LOAD, SETTLE, SAMPLE, SHIFT, OUTPUT.
  - IDLE: on start, capture seed and n_words.
    - If n_words==0: go to IDLE and pulse done on the next cycle; no word is produced.
    - Otherwise go to LOAD and set busy.
  - LOAD: drive ring_challenge=LFSR state and ring_reset=1 for RST_CYC cycles, then go to SETTLE.
  - SETTLE: ring_reset=0 for SETTLE_CYC cycles, then go to SAMPLE.
  - SAMPLE (1 cycle): ones_cnt += sync_response; vote_cnt++.
    - If vote_cnt < VOTES, go to LOAD (same challenge).
    - Otherwise go to SHIFT.
  - SHIFT (1 cycle): bit = (ones_cnt > VOTES/2).
    - word_shift = {word_shift[OUT_W-2:0], bit}; the first bit of a word lands in the MSB.
    - Advance the LFSR; clear ones_cnt and vote_cnt; bit_cnt++.
    - If bit_cnt == OUT_W, load word_data, set word_valid, go to OUTPUT. Otherwise go to LOAD.
  - OUTPUT: hold word_valid and word_data stable until word_ready is sampled high.
    - On the handshake cycle, word_valid drops next cycle and words_left decrements.
    - If words_left reaches 0: done pulses, busy drops, go to IDLE.
    - Otherwise go to LOAD.
    - No evaluation runs during backpressure.
- Per-bit latency: VOTES*(RST_CYC+SETTLE_CYC+1)+1 cycles; 366 with defaults.
- abort, any state except IDLE:
  - Next cycle: IDLE, ring_reset=1, busy=0, word_valid=0, no done.
  - A partial word is discarded.
  - abort has priority over a simultaneous word_ready handshake; that word counts as not delivered.
- start together with abort in IDLE: abort wins; start is ignored.
- Asynchronous reset mid-run: immediate return to the reset values.

Decomposition:
- Shared package puf_pkg holds:
  - the FSM state enum;
  - LFSR mask constant 0x80200003;
  - the default CHAL_W value.
- One sub-module, puf_lfsr, with ports load, seed, advance, state. It implements the zero-seed substitution.
- The synchronizer and the vote counter stay inline.

Test Plan:
- Ring model with constant response 1; seed=0x1, n_words=1 → word_data=0xFFFFFFFF; word_valid rises 32*366 cycles after busy; done pulses after ready.
- Ring model with response = XOR of the challenge bits; seed=0xACE1ACE1, n_words=2 → two words match a reference model of the LFSR sequence; ring_challenge never changes while ring_reset=0.
- Noisy model flipping 2 of 5 votes → bits unchanged; flipping 3 of 5 → that bit is inverted in word_data.
- word_ready held low 200 cycles → word_data stable, ring_reset=1 throughout, no LOAD activity; accepted on the first ready cycle.
- seed=0 → first ring_challenge is 0x00000001. n_words=0 → done pulses one cycle later; word_valid never asserts.
- abort during SETTLE, and async reset_n low mid-LOAD → next cycle (immediately for reset) ring_reset=1, busy=0, word_valid=0, no done. A new start afterwards produces correct results.
